bcd_convert_sequencer: RTL and testbench

- Drives one shared 4-bit BCD code converter (combinational `a,b,c,d -> e,f,g,h` datapath) to translate a packed multi-digit BCD word, one digit per clock.
- Accepts a word over a valid/ready input handshake and presents digits to the converter least-significant first.
- Reassembles the converted nibbles and returns them over a valid/ready output handshake.
- Sits between a multi-digit producer (counter/display logic) and the single converter instance, so the converter is time-shared instead of replicated DIGITS times.

---
 rtl/bcd_convert_sequencer.sv | 121 ++++++++++++
 tb/tb_bcd_convert_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_sequencer.sv
// Time-shares one combinational BCD code converter across a DIGITS-wide word, one digit per clock.
// Define BCD_SEQ_ERR_CHECK_EN to flag any input digit above 9 on out_err (otherwise out_err is 0).
module bcd_convert_sequencer #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic [3:0]            conv_in,
    input  logic [3:0]            conv_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_err,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] word_q, word_d;
    logic [4*DIGITS-1:0] data_q, data_d;
    logic [3:0]          cur_digit;
    logic                accept;

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = data_q;
    assign conv_in   = (state_q == ST_CONV) ? cur_digit : 4'd0;

    // Digit mux built as a compare loop so the index never needs widening into a bit offset.
    always_comb begin
        cur_digit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDXW'(k)) cur_digit = word_q[4*k +: 4];
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    word_d  = in_data;
                    data_d  = '0;
                    idx_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (idx_q == IDXW'(k)) data_d[4*k +: 4] = conv_out;
                end
                if (idx_q == IDXW'(DIGITS - 1)) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            data_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            data_q  <= data_d;
        end
    end

`ifdef BCD_SEQ_ERR_CHECK_EN
    logic err_q, err_d;

    // Sticky across the word; the raw converter result is still stored for bad digits.
    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if ((state_q == ST_CONV) && (cur_digit > 4'd9)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_convert_sequencer.sv
// Directed bench for bcd_convert_sequencer with an excess-3 converter model (conv_out = conv_in + 3).
module tb_bcd_convert_sequencer;

    localparam int DIGITS = 4;
    localparam int IDXW   = 4;
`ifdef BCD_SEQ_ERR_CHECK_EN
    localparam logic EXP_BAD_ERR = 1'b1;
`else
    localparam logic EXP_BAD_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  conv_in;
    logic [3:0]  conv_out;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    int          cyc = 0;
    int          n_acc = 0;
    int          acc_cyc[8];
    int          n_out = 0;
    logic [15:0] out_log[8];
    int          n_valid_seen = 0;

    bcd_convert_sequencer #(.DIGITS(DIGITS), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .conv_in   (conv_in),
        .conv_out  (conv_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .busy      (busy)
    );

    assign conv_out = conv_in + 4'd3;

    always #5 clk = ~clk;

    // Inputs only change at posedge+1, so the negedge view predicts the next edge's handshakes.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst && in_valid && in_ready) begin
            if (n_acc < 8) acc_cyc[n_acc] = cyc;
            n_acc = n_acc + 1;
        end
        if (!rst && out_valid && out_ready) begin
            if (n_out < 8) out_log[n_out] = out_data;
            n_out = n_out + 1;
        end
        if (out_valid) n_valid_seen = n_valid_seen + 1;
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_word(input logic [15:0] data, output logic [15:0] res,
                            output logic err, output bit ok);
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = data;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(ok);
        res = out_data;
        err = out_err;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0000;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (out_data !== 16'h0000) begin n_errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
        n_checks++; if (conv_in !== 4'h0) begin n_errors++; $display("FAIL reset_conv_in: got %h expected 0", conv_in); end
        n_checks++; if (out_err !== 1'b0) begin n_errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [3:0] exp_d[4];
        exp_d = '{4'h4, 4'h9, 4'h2, 4'h1};
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = 16'h1294;
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL basic_idle_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++; if (conv_in !== exp_d[i]) begin n_errors++; $display("FAIL basic_conv_in[%0d]: got %h expected %h", i, conv_in, exp_d[i]); end
            n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_errors++; $display("FAIL basic_conv_flags[%0d]: got busy=%b in_ready=%b out_valid=%b expected 1 0 0", i, busy, in_ready, out_valid);
            end
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_data !== 16'h45C7) begin n_errors++; $display("FAIL basic_out_data: got %h expected 45c7", out_data); end
        n_checks++; if (out_err !== 1'b0) begin n_errors++; $display("FAIL basic_out_err: got %b expected 0", out_err); end
    endtask

    task automatic test_backpressure();
        bit ok;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h45C7 || in_ready !== 1'b0) begin
                n_errors++; $display("FAIL hold[%0d]: got valid=%b data=%h in_ready=%b expected 1 45c7 0", i, out_valid, out_data, in_ready);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL hold_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL hold_next_timeout: got no out_valid expected out_valid"); end
        n_checks++; if (out_data !== 16'h3333) begin n_errors++; $display("FAIL hold_next_data: got %h expected 3333", out_data); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_invalid_digit();
        logic [15:0] res;
        logic        err;
        bit          ok;
        run_word(16'h12A4, res, err, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL bad_timeout: got no out_valid expected out_valid"); end
        n_checks++; if (res !== 16'h45D7) begin n_errors++; $display("FAIL bad_data: got %h expected 45d7", res); end
        n_checks++; if (err !== EXP_BAD_ERR) begin n_errors++; $display("FAIL bad_err: got %b expected %b", err, EXP_BAD_ERR); end
        run_word(16'h0009, res, err, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL clean_timeout: got no out_valid expected out_valid"); end
        n_checks++; if (res !== 16'h333C) begin n_errors++; $display("FAIL clean_data: got %h expected 333c", res); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL clean_err: got %b expected 0", err); end
    endtask

    task automatic test_back_to_back();
        n_acc = 0;
        n_out = 0;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = 16'h9999;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (n_acc >= 1) break;
        end
        in_data = 16'h0123;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (n_acc >= 2) break;
        end
        in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (n_out >= 2) break;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++; if (n_acc !== 2) begin n_errors++; $display("FAIL b2b_accepts: got %0d expected 2", n_acc); end
        n_checks++; if (n_out !== 2) begin n_errors++; $display("FAIL b2b_outputs: got %0d expected 2", n_out); end
        n_checks++; if (acc_cyc[1] - acc_cyc[0] !== 6) begin n_errors++; $display("FAIL b2b_spacing: got %0d expected 6", acc_cyc[1] - acc_cyc[0]); end
        n_checks++; if (out_log[0] !== 16'hCCCC) begin n_errors++; $display("FAIL b2b_word0: got %h expected cccc", out_log[0]); end
        n_checks++; if (out_log[1] !== 16'h3456) begin n_errors++; $display("FAIL b2b_word1: got %h expected 3456", out_log[1]); end
    endtask

    task automatic test_reset_mid_conv();
        logic [15:0] res;
        logic        err;
        bit          ok;
        @(posedge clk); #1;
        in_valid  = 1'b1;
        in_data   = 16'h8888;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1 || out_data !== 16'h00BB) begin
            n_errors++; $display("FAIL midrst_partial: got busy=%b data=%h expected 1 00bb", busy, out_data);
        end
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL midrst_flags: got valid=%b busy=%b expected 0 0", out_valid, busy);
        end
        n_checks++; if (out_data !== 16'h0000 || conv_in !== 4'h0) begin
            n_errors++; $display("FAIL midrst_data: got data=%h conv_in=%h expected 0000 0", out_data, conv_in);
        end
        n_valid_seen = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        repeat (6) @(negedge clk);
        n_checks++; if (n_valid_seen !== 0) begin n_errors++; $display("FAIL midrst_no_valid: got %0d expected 0", n_valid_seen); end
        run_word(16'h4321, res, err, ok);
        n_checks++; if (!ok) begin n_errors++; $display("FAIL midrst_next_timeout: got no out_valid expected out_valid"); end
        n_checks++; if (res !== 16'h7654) begin n_errors++; $display("FAIL midrst_next_data: got %h expected 7654", res); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_invalid_digit();
        test_back_to_back();
        test_reset_mid_conv();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
